// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath.
// State layout is column-major over a [0:127] vector:
//   byte(r,c) = bits [32c+8r +: 8], so byte 0 is the MSB-most byte.
package aes_pkg;

  localparam int AES_NB = 4;

  typedef logic [0:127] aes_state_t;

  // Bit offset of byte(r,c) inside an aes_state_t.
  function automatic int byte_off(input int r, input int c);
    return 32 * c + 8 * r;
  endfunction

endpackage

// File: rtl/inv_shift_rows_comb.sv
// Purely combinational AES InvShiftRows byte permutation.
// Row r is rotated right by r columns: out byte(r,c) = in byte(r,(c-r) mod 4).
// Ports:
//   state    in  128  input state, [0:127] column-major bytes
//   shifted  out 128  permuted state, same layout
module inv_shift_rows_comb
  import aes_pkg::*;
(
  input  logic [0:127] state,
  output logic [0:127] shifted
);

  always_comb begin
    shifted = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
        shifted[byte_off(r, c) +: 8] = state[byte_off(r, (c - r + AES_NB) % AES_NB) +: 8];
      end
    end
  end

endmodule

// File: rtl/inv_shift_rows_pipe.sv
// Two-stage streaming InvShiftRows + AddRoundKey stage for the AES inverse cipher.
// S1 holds the permuted state (plus key and last); S2 holds state^key and last and
// drives the outputs straight from registers. Full throughput with valid/ready.
// Build option: define INV_SHIFT_ROWS_KEY_EN to XOR in the round key; without it the
// key register is dropped and in_key is ignored (timing/handshake unchanged).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_state, in_key      128-bit state and round key, [0:127] column-major
//   in_last               final-round marker, travels with the data
//   out_valid/out_ready   downstream handshake
//   out_state, out_last   result and delayed marker
//   blk_cnt               count of accepted out_last beats, wraps mod 2**CNT_W
module inv_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_state,
  input  logic [0:127]     in_key,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_state,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_cnt
);

  // vld_pipe[1] = S1 full, vld_pipe[2] = S2 full
  logic [2:1]  vld_pipe;
  aes_state_t  shifted;
  aes_state_t  s1_state;
  aes_state_t  s2_state;
  aes_state_t  s1_mixed;
  logic        s1_last;
  logic        s2_last;
  logic        s1_adv;
  logic [CNT_W-1:0] cnt;

  inv_shift_rows_comb u_isr (
    .state   (in_state),
    .shifted (shifted)
  );

`ifdef INV_SHIFT_ROWS_KEY_EN
  aes_state_t s1_key;

  always_ff @(posedge clk) begin
    if (!rst_n)
      s1_key <= '0;
    else if (in_ready && in_valid)
      s1_key <= in_key;
  end

  assign s1_mixed = s1_state ^ s1_key;
`else
  logic key_unused;
  assign key_unused = ^in_key;
  assign s1_mixed   = s1_state;
`endif

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  assign s1_adv   = !vld_pipe[2] || out_ready;
  // Held low during reset so nothing is accepted into a stage that is being cleared.
  assign in_ready = rst_n && (!vld_pipe[1] || s1_adv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_state <= '0;
      s1_last  <= 1'b0;
      s2_state <= '0;
      s2_last  <= 1'b0;
      cnt      <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_state <= shifted;
          s1_last  <= in_last;
        end
      end
      if (s1_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        // Data only loads on a real beat so out_state holds its value while empty.
        if (vld_pipe[1]) begin
          s2_state <= s1_mixed;
          s2_last  <= s1_last;
        end
      end
      if (vld_pipe[2] && out_ready && s2_last)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_state = s2_state;
  assign out_last  = s2_last;
  assign blk_cnt   = cnt;

endmodule

// File: tb/tb_inv_shift_rows_pipe.sv
module tb_inv_shift_rows_pipe;

  localparam logic [127:0] PAT  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] EXP1 = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] EXPK = 128'hfff2f5f8_fbfef1f4_f7fafdf0_f3f6f9fc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         out_last;
  logic [7:0]   blk_cnt;

  int checks = 0;
  int errors = 0;

  inv_shift_rows_pipe #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_last  (out_last),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  // Adding k to every byte commutes with any byte permutation, so the expected
  // result for PAT+k is EXP1+k.
  function automatic logic [127:0] add_bytes(input logic [127:0] v, input logic [7:0] k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*i +: 8] + k;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_state !== '0) begin errors++; $display("FAIL reset_out_state got %h want 0", out_state); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (blk_cnt !== 8'd0) begin errors++; $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic single_beat(input string name, input logic [127:0] key, input logic [127:0] exp);
    in_valid = 1'b1; in_state = PAT; in_key = key; in_last = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
    cycle();
    in_valid = 1'b0; in_key = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b want 0", name, out_valid); end
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", name, out_valid); end
    checks++; if (out_state !== exp) begin errors++; $display("FAIL %s_state got %h want %h", name, out_state, exp); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got %b want 0", name, out_valid); end
    checks++; if (out_state !== exp) begin errors++; $display("FAIL %s_hold got %h want %h", name, out_state, exp); end
  endtask

  task automatic test_basic();
    single_beat("basic", '0, EXP1);
  endtask

  task automatic test_key();
`ifdef INV_SHIFT_ROWS_KEY_EN
    single_beat("key", {128{1'b1}}, EXPK);
`else
    single_beat("key", {128{1'b1}}, EXP1);
`endif
  endtask

  // Beat t goes in on edge t+1 and is on the outputs after edge t+2; last on beat 3.
  task automatic test_back_to_back();
    out_ready = 1'b1; in_key = '0;
    for (int t = 0; t < 11; t++) begin
      in_valid = (t < 8);
      in_state = add_bytes(PAT, 8'(t + 1));
      in_last  = (t == 3);
      #1;
      if (t < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready t=%0d got %b want 1", t, in_ready); end
      end
      cycle();
      if (t >= 1 && t <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_state !== add_bytes(EXP1, 8'(t)) || out_last !== (t - 1 == 3)) begin
          errors++;
          $display("FAIL b2b_out t=%0d got v=%b %h l=%b want v=1 %h l=%b",
                   t, out_valid, out_state, out_last, add_bytes(EXP1, 8'(t)), (t - 1 == 3));
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle t=%0d got %b want 0", t, out_valid); end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (blk_cnt !== 8'd1) begin errors++; $display("FAIL b2b_blk_cnt got %0d want 1", blk_cnt); end
  endtask

  task automatic test_stall();
    logic [127:0] got[$];
    int sent = 0;
    int cyc = 0;
    logic fire_in;
    in_key = '0; in_last = 1'b0;
    while (got.size() < 4 && cyc < 40) begin
      in_valid  = (sent < 4);
      in_state  = add_bytes(PAT, 8'(8'h20 + sent));
      out_ready = (cyc >= 5);
      #1;
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_state);
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got %b want 0", cyc, in_ready); end
        checks++; if (sent != 2) begin errors++; $display("FAIL stall_accepted cyc=%0d got %0d want 2", cyc, sent); end
      end
      cycle();
      if (fire_in) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== add_bytes(EXP1, 8'(8'h20 + i))) begin
        errors++; $display("FAIL stall_order i=%0d got %h want %h", i, got[i], add_bytes(EXP1, 8'(8'h20 + i)));
      end
    end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra got %b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    int outs = 0;
    int lastbad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    in_state = PAT; in_key = '0; in_last = 1'b1;
    for (int t = 0; t < 300 && outs < 257; t++) begin
      in_valid = (t < 257);
      #1;
      if (out_valid) begin
        outs++;
        if (out_last !== 1'b1) lastbad++;
      end
      if (outs == 255 && out_valid) begin
        checks++; if (blk_cnt !== 8'd254) begin errors++; $display("FAIL wrap_mid got %0d want 254", blk_cnt); end
      end
      cycle();
    end
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    checks++; if (outs != 257) begin errors++; $display("FAIL wrap_outs got %0d want 257", outs); end
    checks++; if (lastbad != 0) begin errors++; $display("FAIL wrap_out_last got %0d bad want 0", lastbad); end
    checks++; if (blk_cnt !== 8'd1) begin errors++; $display("FAIL wrap_blk_cnt got %0d want 1", blk_cnt); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; in_key = '0; in_last = 1'b0;
    in_valid = 1'b1; in_state = add_bytes(PAT, 8'h40);
    cycle();
    in_state = add_bytes(PAT, 8'h41);
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (blk_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_blk_cnt got %0d want 0", blk_cnt); end
    rst_n = 1'b1; out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %b want 0", out_valid); end
    single_beat("after_rst", '0, EXP1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
